// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared constants for the bit-serial adder: FSM state encodings
//            and a clog2 helper used to size the bit counter.
// Ports    : none (package)
// Config   : SERIAL_SUB_EN (see serial_adder.sv) does not affect this file.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_FIN  = 2'd2;

    // Ceiling log2; returns at least 1 so a counter never ends up zero-width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Request/response bundle between a requester and the serial
//            adder.
// Signals  : start        requester -> adder, begin an operation
//            a, b, cin    requester -> adder, operands (sampled on start)
//            sub          requester -> adder, subtract select
//                         (only when SERIAL_SUB_EN is defined)
//            busy         adder -> requester, bits in progress
//            done         adder -> requester, one-cycle result-valid pulse
//            sum, cout    adder -> requester, result
// Modports : master (requester side), slave (adder side)
// Config   : SERIAL_SUB_EN adds the sub signal.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Combinational 1-bit full adder cell; the only arithmetic
//            element of the serial adder.
// Ports    : x_i, y_i   operand bits
//            cin_i      carry in
//            sum_o      sum bit
//            cout_o     carry out
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic x_i,
    input  wire logic y_i,
    input  wire logic cin_i,
    output logic      sum_o,
    output logic      cout_o
);

    assign sum_o  = x_i ^ y_i ^ cin_i;
    assign cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, LSB first, using one full_adder
//            cell and one carry flip-flop. An accepted start takes WIDTH
//            cycles; done pulses for one cycle when sum/cout are final.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            bus        serial_adder_if.slave (start/a/b/cin[/sub] in,
//                       busy/done/sum/cout out)
// Params   : WIDTH      operand/result width, >= 2
// Config   : SERIAL_SUB_EN - when defined, bus.sub=1 computes a - b - cin
//            (cin as borrow-in) and cout reports borrow-out.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    serial_adder_if.slave  bus
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               carry_q, carry_d;
    logic               cout_q,  cout_d;
    logic               sub_q,   sub_d;

    logic               accept;
    logic               sub_in;
    logic               fa_sum;
    logic               fa_cout;

`ifdef SERIAL_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // start is only honoured when no operation is in flight.
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_FIN));

    full_adder u_fa (
        .x_i    (a_sh_q[0]),
        .y_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
            ST_FIN:  state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (state_q == ST_RUN);
        bus.done = (state_q == ST_FIN);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        if (accept) begin
            // Subtraction is a + ~b + ~cin, so invert b and cin at load.
            a_sh_d  = bus.a;
            b_sh_d  = sub_in ? ~bus.b : bus.b;
            carry_d = sub_in ^ bus.cin;
            sub_d   = sub_in;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_cout;
            // Result enters at the MSB so after WIDTH shifts bit 0 is at LSB.
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            // In subtract mode a missing final carry means a borrow.
            cout_d  = sub_q ^ fa_cout;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

endmodule : serial_adder
`default_nettype wire
